hazard_unit: RTL and testbench

// Parametrised pipeline hazard unit for the 16-bit core; successor to the decode-stage forwarding/branch logic.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hazard_unit_sat_counter.sv | 31 +++
 rtl/hazard_unit.sv | 166 ++++++++++++++++
 tb/tb_hazard_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard unit: FSM states, scoreboard entry and stage indices.
package hazard_pkg;

    localparam int unsigned RSIZE_MAX = 8;

    localparam int unsigned STG_EX  = 1;
    localparam int unsigned STG_MEM = 2;
    localparam int unsigned STG_WB  = 3;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } hz_state_e;

    // rd is held zero-extended to RSIZE_MAX so one entry type serves any RSIZE up to that limit
    typedef struct packed {
        logic                 vld;
        logic [RSIZE_MAX-1:0] rd;
        logic                 wen;
        logic                 ld;
    } sb_entry_t;

    function automatic sb_entry_t sb_bubble();
        sb_entry_t e;
        e = '0;
        return e;
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] q_q;
    logic [CNT_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (inc && (q_q != '1)) begin
            q_d = q_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard unit: scoreboard of in-flight destinations, one-hot bypass selects,
// load-use stall, timed branch flush and saturating stall/flush event counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned RSIZE     = 4,
    parameter int unsigned NSTAGE    = STG_WB,
    parameter int unsigned LOAD_LAT  = STG_MEM,
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned ZERO_REG  = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [RSIZE-1:0]  id_rs,
    input  logic [RSIZE-1:0]  id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [RSIZE-1:0]  id_rd,
    input  logic              id_wen,
    input  logic              id_is_load,
    input  logic              br_taken,
    input  logic              mem_stall,
    output logic [NSTAGE-1:0] fwd_rs,
    output logic [NSTAGE-1:0] fwd_rt,
    output logic              stall,
    output logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int unsigned FC_W = $clog2(FLUSH_CYC + 1);
    localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYC - 1);

    sb_entry_t [NSTAGE:1] sb_q;
    sb_entry_t [NSTAGE:1] sb_d;

    hz_state_e       state_q;
    hz_state_e       state_d;
    logic [FC_W-1:0] fc_q;
    logic [FC_W-1:0] fc_d;

    logic [NSTAGE-1:0] match_rs, match_rt;
    logic [NSTAGE-1:0] younger_rs, younger_rt;
    logic [NSTAGE-1:0] sel_rs, sel_rt;
    logic [NSTAGE-1:0] haz_rs, haz_rt;

    logic zero_rs;
    logic zero_rt;
    logic hazard;
    logic issue;
    logic stall_inc;

    assign zero_rs = (ZERO_REG != 0) && (id_rs == '0);
    assign zero_rt = (ZERO_REG != 0) && (id_rt == '0);

    // Per-stage match; a stage is selected only if no younger (lower-index) stage matched
    for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
        localparam int unsigned K = STG_EX + g;
        localparam logic LOAD_EARLY = (K < LOAD_LAT);
        sb_entry_t ent;

        assign ent = sb_q[K];

        assign match_rs[g] = ent.vld & ent.wen & id_rs_used & ~zero_rs
                           & (ent.rd == RSIZE_MAX'(id_rs));
        assign match_rt[g] = ent.vld & ent.wen & id_rt_used & ~zero_rt
                           & (ent.rd == RSIZE_MAX'(id_rt));

        if (g == 0) begin : g_first
            assign younger_rs[g] = 1'b0;
            assign younger_rt[g] = 1'b0;
        end else begin : g_rest
            assign younger_rs[g] = younger_rs[g-1] | match_rs[g-1];
            assign younger_rt[g] = younger_rt[g-1] | match_rt[g-1];
        end

        assign sel_rs[g] = match_rs[g] & ~younger_rs[g];
        assign sel_rt[g] = match_rt[g] & ~younger_rt[g];
        assign haz_rs[g] = sel_rs[g] & ent.ld & LOAD_EARLY;
        assign haz_rt[g] = sel_rt[g] & ent.ld & LOAD_EARLY;
    end

    // A load result not yet available kills that source's bypass
    assign fwd_rs = (|haz_rs) ? '0 : sel_rs;
    assign fwd_rt = (|haz_rt) ? '0 : sel_rt;

    assign hazard    = (|haz_rs) | (|haz_rt);
    assign flush     = br_taken | (state_q == ST_FLUSH);
    assign stall     = hazard & id_valid & ~flush;
    assign issue     = id_valid & ~stall & ~flush & ~mem_stall;
    assign stall_inc = stall & ~mem_stall;

    // Scoreboard advance: shift toward older stages, new entry or bubble into stage 1
    always_comb begin
        sb_d = sb_q;
        if (!mem_stall) begin
            for (int k = int'(NSTAGE); k >= 2; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            if (issue) begin
                sb_d[1] = '{vld: 1'b1, rd: RSIZE_MAX'(id_rd), wen: id_wen, ld: id_is_load};
            end else begin
                sb_d[1] = sb_bubble();
            end
        end
    end

    // Flush sequencer; a branch seen under mem_stall still (re)arms it so no flush cycle is lost
    always_comb begin
        state_d = state_q;
        fc_d    = fc_q;
        unique case (state_q)
            ST_RUN: begin
                if (br_taken && (FLUSH_CYC > 1)) begin
                    state_d = ST_FLUSH;
                    fc_d    = FC_RELOAD;
                end
            end
            ST_FLUSH: begin
                if (br_taken) begin
                    fc_d = FC_RELOAD;
                end else if (!mem_stall) begin
                    if (fc_q == FC_W'(1)) begin
                        state_d = ST_RUN;
                        fc_d    = '0;
                    end else begin
                        fc_d = fc_q - FC_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                fc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q    <= '0;
            state_q <= ST_RUN;
            fc_q    <= '0;
        end else begin
            sb_q    <= sb_d;
            state_q <= state_d;
            fc_q    <= fc_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .q   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (br_taken),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against an in-bench pipeline model.
module tb_hazard_unit;

    localparam int unsigned RS  = 4;
    localparam int unsigned NS  = 3;
    localparam int unsigned LL  = 2;
    localparam int unsigned FC  = 2;
    localparam int unsigned ZR  = 1;
    localparam int unsigned CW  = 5;
    localparam int          SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [RS-1:0] id_rs, id_rt, id_rd;
    logic          id_rs_used, id_rt_used, id_wen, id_is_load;
    logic          br_taken, mem_stall;
    logic [NS-1:0] fwd_rs, fwd_rt;
    logic          stall, flush;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_unit #(
        .RSIZE(RS), .NSTAGE(NS), .LOAD_LAT(LL), .FLUSH_CYC(FC), .ZERO_REG(ZR), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wen(id_wen),
        .id_is_load(id_is_load), .br_taken(br_taken), .mem_stall(mem_stall),
        .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .stall(stall), .flush(flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: list of in-flight instructions, index 1 = youngest
    typedef struct {
        bit vld;
        int rd;
        bit wen;
        bit ld;
    } ent_t;

    ent_t pipe [1:NS];
    int   flush_left = 0;
    int   m_stall_cnt = 0;
    int   m_flush_cnt = 0;
    bit   armed = 1'b0;

    function automatic void src_eval(input int src, input bit used,
                                     output logic [NS-1:0] f, output bit haz);
        f   = '0;
        haz = 1'b0;
        if (!used || (ZR != 0 && src == 0)) return;
        for (int k = 1; k <= int'(NS); k++) begin
            if (pipe[k].vld && pipe[k].wen && pipe[k].rd == src) begin
                if (pipe[k].ld && k < int'(LL)) haz = 1'b1;
                else f[k-1] = 1'b1;
                return;
            end
        end
    endfunction

    function automatic void model_out(output logic [NS-1:0] fr, output logic [NS-1:0] ft,
                                      output bit st, output bit fl);
        bit hr, ht;
        src_eval(int'(id_rs), id_rs_used, fr, hr);
        src_eval(int'(id_rt), id_rt_used, ft, ht);
        fl = br_taken || (flush_left > 0);
        st = (hr || ht) && id_valid && !fl;
    endfunction

    always @(posedge clk) begin
        logic [NS-1:0] fr, ft;
        bit st, fl, iss;
        if (rst) begin
            for (int k = 1; k <= int'(NS); k++) pipe[k] = '{0, 0, 0, 0};
            flush_left  = 0;
            m_stall_cnt = 0;
            m_flush_cnt = 0;
            armed       = 1'b1;
        end else begin
            model_out(fr, ft, st, fl);
            iss = id_valid && !st && !fl && !mem_stall;
            if (br_taken) begin
                if (m_flush_cnt < SAT) m_flush_cnt++;
                flush_left = int'(FC) - 1;
            end else if (!mem_stall && flush_left > 0) begin
                flush_left--;
            end
            if (st && !mem_stall && m_stall_cnt < SAT) m_stall_cnt++;
            if (!mem_stall) begin
                for (int k = int'(NS); k >= 2; k--) pipe[k] = pipe[k-1];
                if (iss) pipe[1] = '{1, int'(id_rd), id_wen, id_is_load};
                else     pipe[1] = '{0, 0, 0, 0};
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic [NS-1:0] fr, ft;
        bit st, fl;
        if (armed) begin
            model_out(fr, ft, st, fl);
            chk("m_fwd_rs", int'(fwd_rs), int'(fr));
            chk("m_fwd_rt", int'(fwd_rt), int'(ft));
            chk("m_stall", int'(stall), int'(st));
            chk("m_flush", int'(flush), int'(fl));
            chk("m_stall_cnt", int'(stall_cnt), m_stall_cnt);
            chk("m_flush_cnt", int'(flush_cnt), m_flush_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                       input int rd, input bit wen, input bit ld, input bit br, input bit ms);
        id_valid   = v;
        id_rs      = RS'(rs);
        id_rt      = RS'(rt);
        id_rs_used = rsu;
        id_rt_used = rtu;
        id_rd      = RS'(rd);
        id_wen     = wen;
        id_is_load = ld;
        br_taken   = br;
        mem_stall  = ms;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_fwd_rs", int'(fwd_rs), 0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_flush", int'(flush), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        chk("rst_flush_cnt", int'(flush_cnt), 0);

        // ALU result forwarded from EX, MEM, WB, then register file
        drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); tick();
        drv(0, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("fwd_ex", int'(fwd_rs), 'b001); tick();
        @(negedge clk); chk("fwd_mem", int'(fwd_rs), 'b010); tick();
        @(negedge clk); chk("fwd_wb", int'(fwd_rs), 'b100); tick();
        @(negedge clk); chk("fwd_rf", int'(fwd_rs), 'b000);

        // Load-use: one stall, then bypass from MEM
        drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); tick();
        drv(1, 0, 5, 0, 1, 6, 1, 0, 0, 0);
        @(negedge clk); chk("lu_stall", int'(stall), 1); chk("lu_fwd_rt", int'(fwd_rt), 0);
        tick();
        @(negedge clk); chk("lu_stall2", int'(stall), 0); chk("lu_fwd_mem", int'(fwd_rt), 'b010);
        chk("lu_stall_cnt", int'(stall_cnt), 1);
        tick();

        // r5 in stages 1 and 3: youngest wins
        drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); tick();
        drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); tick();
        drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); tick();
        drv(0, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("young_wins", int'(fwd_rs), 'b001);
        // r0 is never forwarded nor stalled on, even behind a load to r0
        drv(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); tick();
        drv(1, 0, 0, 0, 1, 8, 1, 0, 0, 0);
        @(negedge clk); chk("r0_fwd", int'(fwd_rt), 0); chk("r0_stall", int'(stall), 0);
        tick();

        // Single taken branch: two flush cycles
        drv(1, 0, 0, 0, 0, 9, 1, 0, 1, 0);
        @(negedge clk); chk("br_flush0", int'(flush), 1); chk("br_nostall", int'(stall), 0);
        tick(); drv(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        @(negedge clk); chk("br_flush1", int'(flush), 1);
        tick();
        @(negedge clk); chk("br_flush_end", int'(flush), 0); chk("br_cnt1", int'(flush_cnt), 1);
        idle();
        tick();

        // Back-to-back taken branches: three flush cycles
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        idle();
        @(negedge clk); chk("br2_flush2", int'(flush), 1); tick();
        @(negedge clk); chk("br2_flush_end", int'(flush), 0); chk("br2_cnt", int'(flush_cnt), 3);

        // Load-use under mem_stall: frozen for 4 cycles, then 1 stall, then bypass
        drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); tick();
        drv(1, 0, 5, 0, 1, 6, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("ms_stall", int'(stall), 1); chk("ms_cnt", int'(stall_cnt), 1);
            tick();
        end
        drv(1, 0, 5, 0, 1, 6, 1, 0, 0, 0);
        @(negedge clk); chk("ms_rel_stall", int'(stall), 1); tick();
        @(negedge clk); chk("ms_rel_go", int'(stall), 0); chk("ms_fwd_mem", int'(fwd_rt), 'b010);
        chk("ms_cnt2", int'(stall_cnt), 2);
        tick();

        // Reset in the middle of a flush with a full scoreboard
        drv(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); tick();
        drv(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); tick();
        drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        idle(); rst = 1'b1; tick(); rst = 1'b0;
        drv(1, 1, 2, 1, 1, 4, 1, 0, 0, 0);
        @(negedge clk);
        chk("rr_flush", int'(flush), 0); chk("rr_fwd_rs", int'(fwd_rs), 0);
        chk("rr_fwd_rt", int'(fwd_rt), 0); chk("rr_stall_cnt", int'(stall_cnt), 0);
        chk("rr_flush_cnt", int'(flush_cnt), 0);
        tick();

        // Saturate the stall counter
        for (int i = 0; i < SAT + 4; i++) begin
            drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); tick();
            drv(1, 0, 5, 0, 1, 6, 1, 0, 0, 0); tick(); tick();
        end
        idle();
        @(negedge clk); chk("sat_stall_cnt", int'(stall_cnt), SAT);
        tick();

        // Random traffic, model-checked every cycle
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            drv($urandom_range(0, 9) < 8,
                int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                int'($urandom_range(0, 5)), $urandom_range(0, 4) != 0,
                $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
                $urandom_range(0, 6) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
